// File: rtl/ap_accum_array.sv
// -----------------------------------------------------------------------------
// ap_accum_array
//
// Bank of NCH independent signed accumulators fed by one valid/ready input
// stream. Each beat adds in_data into the accumulator of channel in_ch, either
// wrapping or saturating on two's-complement overflow. A beat flagged in_last
// emits the channel's final sum into a single-entry output register and clears
// the channel's accumulator and sticky overflow flag in the same edge.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   sat_mode   : 1 = saturate on overflow, 0 = wrap (sampled per accepted beat)
//   in_valid   : input beat offered
//   in_ready   : input beat can be accepted this cycle
//   in_ch      : target channel (values >= NCH are accepted and dropped)
//   in_data    : signed addend
//   in_last    : final beat of the channel's accumulation
//   out_valid  : result held on out_* ports
//   out_ready  : consumer accepts the result
//   out_ch     : channel of the emitted result
//   out_data   : signed accumulated result
//   out_ovf    : overflow seen on any beat of the emitted accumulation
//   ovf_flags  : live sticky overflow flag per channel
// -----------------------------------------------------------------------------
module ap_accum_array #(
  parameter int WIDTH = 68,
  parameter int NCH   = 4,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sat_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHW-1:0]          in_ch,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHW-1:0]          out_ch,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_ovf,
  output logic [NCH-1:0]          ovf_flags
);

  // Index width that exactly addresses the accumulator bank; in_ch may be
  // wider so that out-of-range channels can be presented and dropped.
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] acc_q [NCH];
  logic signed [WIDTH-1:0] acc_d [NCH];
  logic [NCH-1:0]          ovf_q, ovf_d;

  logic                    out_valid_q, out_valid_d;
  logic [CHW-1:0]          out_ch_q, out_ch_d;
  logic signed [WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_ovf_q, out_ovf_d;

  // ---------------------------------------------------------------------------
  // Handshake and channel decode
  // ---------------------------------------------------------------------------
  logic            beat_acc;   // handshake completed this edge
  logic            ch_ok;      // channel addresses a real accumulator
  logic            beat_ok;    // accepted beat that actually updates state
  logic [IDXW-1:0] ch_idx;

  // The output register is single-entry: input stalls only when it is full
  // and the consumer is not draining it this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign beat_acc = in_valid && in_ready;

  assign ch_ok   = (32'(in_ch) < 32'(NCH));
  assign ch_idx  = ch_ok ? IDXW'(in_ch) : '0;
  assign beat_ok = beat_acc && ch_ok;

  // ---------------------------------------------------------------------------
  // Adder with overflow detection and optional saturation
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] cur_acc;
  logic signed [WIDTH-1:0] sum_tmp;
  logic                    pos_ovf, neg_ovf, beat_ovf;
  logic signed [WIDTH-1:0] next_val;

  assign cur_acc = acc_q[ch_idx];
  assign sum_tmp = cur_acc + in_data;

  // Overflow is only possible when both operands share a sign and the
  // truncated sum's sign differs from it.
  assign pos_ovf  = !cur_acc[WIDTH-1] && !in_data[WIDTH-1] &&  sum_tmp[WIDTH-1];
  assign neg_ovf  =  cur_acc[WIDTH-1] &&  in_data[WIDTH-1] && !sum_tmp[WIDTH-1];
  assign beat_ovf = pos_ovf || neg_ovf;

  // The clamped value is written back as-is, so later beats build on the
  // saturated value with no hidden extra precision.
  always_comb begin
    next_val = sum_tmp;
    if (sat_mode && pos_ovf) begin
      next_val = MAX_POS;
    end else if (sat_mode && neg_ovf) begin
      next_val = MIN_NEG;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    // Consumer drains the held result.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (beat_ok) begin
      if (in_last) begin
        // A last beat accepted in the same edge as a drain replaces the
        // drained result, keeping out_valid high.
        out_valid_d    = 1'b1;
        out_ch_d       = in_ch;
        out_data_d     = next_val;
        out_ovf_d      = ovf_q[ch_idx] || beat_ovf;
        acc_d[ch_idx]  = '0;
        ovf_d[ch_idx]  = 1'b0;
      end else begin
        acc_d[ch_idx]  = next_val;
        ovf_d[ch_idx]  = ovf_q[ch_idx] || beat_ovf;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator bank is a set of flops, not a RAM, and must be
      // cleared on reset, so every entry is reset explicitly.
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign ovf_flags = ovf_q;

endmodule
